// File: rtl/l1route_shift_scheduler_pkg.sv
// Shared constants and FSM encoding for the 1st-level circular-shift router
// sequencer. The shifter geometry constants are also consumed by the shifter
// wrapper, so keep them in one place.
package l1route_shift_scheduler_pkg;

  localparam int STRIDE_WIDTH          = 5;
  localparam int STRIDE_UNIT_SIZE      = 51;
  localparam int BITWIDTH_SHIFT_FACTOR = 6;
  localparam int LAYER_NUM             = 4;
  localparam int LAYER_W               = 2;
  localparam int SHIFTER_LATENCY       = 2;
  localparam int BURST_W               = 4;
  localparam int PERF_W                = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_e;

  typedef logic [BITWIDTH_SHIFT_FACTOR-1:0] shift_t;

  // A table write is legal only for an existing stride unit and an in-range shift.
  function automatic logic cfg_write_ok(input logic [2:0] stride, input shift_t shift);
    return (stride < 3'(STRIDE_WIDTH)) &&
           (shift < BITWIDTH_SHIFT_FACTOR'(STRIDE_UNIT_SIZE));
  endfunction

endpackage

// File: rtl/l1route_valid_delay.sv
// Delay line carrying {last, valid} alongside the shifter pipeline so output
// beats can be qualified. It never stalls, matching the enable-less shifter.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_valid, i_last   beat entering the shifter
//   o_valid, o_last   same beat leaving the shifter DEPTH cycles later
module l1route_valid_delay
  import l1route_shift_scheduler_pkg::*;
#(
  parameter int DEPTH = SHIFTER_LATENCY
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_valid,
  input  logic i_last,
  output logic o_valid,
  output logic o_last
);

  logic [1:0] r_pipe [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= 2'b00;
    end else begin
      r_pipe[0] <= {i_last, i_valid};
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_valid = r_pipe[DEPTH-1][0];
  assign o_last  = r_pipe[DEPTH-1][1];

endmodule

// File: rtl/l1route_shift_scheduler.sv
// Sequencer for the column-wise 1st-level circular-shift router: holds the
// per-layer shift-factor table, presents one layer's factors to the stride
// units for a burst, issues the beats and tracks them through the shifter.
// Ports:
//   sys_clk, rst                      clock, synchronous active-high reset
//   cfg_we_i/layer/stride/shift       table write; cfg_err_o pulses on a rejected write
//   start_i, layer_i, burst_len_m1_i  burst request (sampled in IDLE only)
//   hold_i                            suppress beat issue this cycle (ISSUE only)
//   busy_o, done_o                    status / completion pulse
//   strideN_shift_factor_o            factors to the five stride units
//   src_valid_o, dst_valid_o, dst_last_o  beat qualifiers at shifter in/out
// Build option L1ROUTE_PERF_CNT_EN adds perf_burst_cnt_o / perf_hold_cnt_o.
//
// state | meaning
// IDLE  | waiting for start_i; factors hold last loaded value
// LOAD  | register table[layer] onto the factor outputs, load beat counter
// ISSUE | present beats (stalled by hold_i) until the final beat goes out
// DRAIN | wait for the final beat to leave the shifter pipeline
// DONE  | one-cycle completion pulse
module l1route_shift_scheduler
  import l1route_shift_scheduler_pkg::*;
(
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               cfg_we_i,
  input  logic [LAYER_W-1:0] cfg_layer_i,
  input  logic [2:0]         cfg_stride_i,
  input  shift_t             cfg_shift_i,
  output logic               cfg_err_o,
  input  logic               start_i,
  input  logic [LAYER_W-1:0] layer_i,
  input  logic [BURST_W-1:0] burst_len_m1_i,
  input  logic               hold_i,
  output logic               busy_o,
  output logic               done_o,
  output shift_t             stride0_shift_factor_o,
  output shift_t             stride1_shift_factor_o,
  output shift_t             stride2_shift_factor_o,
  output shift_t             stride3_shift_factor_o,
  output shift_t             stride4_shift_factor_o,
  output logic               src_valid_o,
  output logic               dst_valid_o,
  output logic               dst_last_o
`ifdef L1ROUTE_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]  perf_burst_cnt_o,
  output logic [PERF_W-1:0]  perf_hold_cnt_o
`endif
);

  sched_state_e       r_state, w_state_nxt;
  logic [LAYER_W-1:0] r_layer;
  logic [BURST_W-1:0] r_len_m1;
  logic [BURST_W-1:0] r_cnt;
  shift_t             r_table [LAYER_NUM][STRIDE_WIDTH];
  shift_t             r_factor [STRIDE_WIDTH];
  logic               r_cfg_err;
  logic               w_cfg_ok, w_issue, w_issue_last, w_dst_valid, w_dst_last;

  assign w_cfg_ok     = cfg_write_ok(cfg_stride_i, cfg_shift_i);
  assign w_issue      = (r_state == ST_ISSUE) && !hold_i;
  assign w_issue_last = w_issue && (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start_i) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (w_issue_last) w_state_nxt = ST_DRAIN;
      // Last flag at the pipeline output means the burst has fully drained.
      ST_DRAIN: if (w_dst_last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_layer  <= '0;
      r_len_m1 <= '0;
      r_cnt    <= '0;
      for (int s = 0; s < STRIDE_WIDTH; s++) r_factor[s] <= '0;
    end else begin
      if ((r_state == ST_IDLE) && start_i) begin
        r_layer  <= layer_i;
        r_len_m1 <= burst_len_m1_i;
      end
      // Factors change only here, so every in-flight beat sees one set.
      if (r_state == ST_LOAD) begin
        for (int s = 0; s < STRIDE_WIDTH; s++) r_factor[s] <= r_table[r_layer][s];
        r_cnt <= r_len_m1;
      end else if (w_issue && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Writes land at the edge, so a LOAD on the same edge reads the old entry.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int l = 0; l < LAYER_NUM; l++)
        for (int s = 0; s < STRIDE_WIDTH; s++) r_table[l][s] <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      if (cfg_we_i && w_cfg_ok) r_table[cfg_layer_i][cfg_stride_i] <= cfg_shift_i;
      r_cfg_err <= cfg_we_i && !w_cfg_ok;
    end
  end

  l1route_valid_delay #(.DEPTH(SHIFTER_LATENCY)) u_valid_delay (
    .i_clk   (sys_clk),
    .i_rst   (rst),
    .i_valid (w_issue),
    .i_last  (w_issue_last),
    .o_valid (w_dst_valid),
    .o_last  (w_dst_last)
  );

`ifdef L1ROUTE_PERF_CNT_EN
  logic [PERF_W-1:0] r_perf_burst, r_perf_hold;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_perf_burst <= '0;
      r_perf_hold  <= '0;
    end else begin
      if ((r_state == ST_DONE) && (r_perf_burst != '1)) r_perf_burst <= r_perf_burst + 1'b1;
      if ((r_state == ST_ISSUE) && hold_i && (r_perf_hold != '1)) r_perf_hold <= r_perf_hold + 1'b1;
    end
  end

  assign perf_burst_cnt_o = r_perf_burst;
  assign perf_hold_cnt_o  = r_perf_hold;
`endif

  assign busy_o                 = (r_state != ST_IDLE);
  assign done_o                 = (r_state == ST_DONE);
  assign cfg_err_o              = r_cfg_err;
  assign src_valid_o            = w_issue;
  assign dst_valid_o            = w_dst_valid;
  assign dst_last_o             = w_dst_last;
  assign stride0_shift_factor_o = r_factor[0];
  assign stride1_shift_factor_o = r_factor[1];
  assign stride2_shift_factor_o = r_factor[2];
  assign stride3_shift_factor_o = r_factor[3];
  assign stride4_shift_factor_o = r_factor[4];

endmodule

// File: tb/tb_l1route_shift_scheduler.sv
// Directed bench for l1route_shift_scheduler. Each burst is observed over a
// fixed window; bit c of a pattern word is the output level in cycle c, where
// cycle 0 is the cycle start_i is presented.
module tb_l1route_shift_scheduler;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       cfg_we_i;
  logic [1:0] cfg_layer_i;
  logic [2:0] cfg_stride_i;
  logic [5:0] cfg_shift_i;
  logic       cfg_err_o;
  logic       start_i;
  logic [1:0] layer_i;
  logic [3:0] burst_len_m1_i;
  logic       hold_i;
  logic       busy_o, done_o, src_valid_o, dst_valid_o, dst_last_o;
  logic [5:0] sf0, sf1, sf2, sf3, sf4;
`ifdef L1ROUTE_PERF_CNT_EN
  logic [15:0] perf_burst_cnt_o, perf_hold_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] q_src, q_dst, q_last, q_done, q_busy;
  logic [29:0] q_fac_c1, q_fac_c2, q_fac_end;
  logic [29:0] w_fac;

  localparam int WIN = 12;

  assign w_fac = {sf0, sf1, sf2, sf3, sf4};

  always #5 sys_clk = ~sys_clk;

  l1route_shift_scheduler dut (
    .sys_clk                (sys_clk),
    .rst                    (rst),
    .cfg_we_i               (cfg_we_i),
    .cfg_layer_i            (cfg_layer_i),
    .cfg_stride_i           (cfg_stride_i),
    .cfg_shift_i            (cfg_shift_i),
    .cfg_err_o              (cfg_err_o),
    .start_i                (start_i),
    .layer_i                (layer_i),
    .burst_len_m1_i         (burst_len_m1_i),
    .hold_i                 (hold_i),
    .busy_o                 (busy_o),
    .done_o                 (done_o),
    .stride0_shift_factor_o (sf0),
    .stride1_shift_factor_o (sf1),
    .stride2_shift_factor_o (sf2),
    .stride3_shift_factor_o (sf3),
    .stride4_shift_factor_o (sf4),
    .src_valid_o            (src_valid_o),
    .dst_valid_o            (dst_valid_o),
    .dst_last_o             (dst_last_o)
`ifdef L1ROUTE_PERF_CNT_EN
    ,
    .perf_burst_cnt_o       (perf_burst_cnt_o),
    .perf_hold_cnt_o        (perf_hold_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] l, input logic [2:0] s, input logic [5:0] v);
    cfg_we_i = 1'b1; cfg_layer_i = l; cfg_stride_i = s; cfg_shift_i = v;
    tick();
    cfg_we_i = 1'b0;
  endtask

  task automatic run_burst(input logic [1:0] lay, input logic [3:0] lm1,
                           input logic [31:0] hold_m, input logic [31:0] start_m,
                           input int wr_c, input logic [1:0] wr_l, input logic [2:0] wr_s,
                           input logic [5:0] wr_v, input int rst_c);
    q_src = '0; q_dst = '0; q_last = '0; q_done = '0; q_busy = '0;
    q_fac_c1 = '0; q_fac_c2 = '0;
    for (int c = 0; c < WIN; c++) begin
      start_i        = (c == 0) || start_m[c];
      layer_i        = (c == 0) ? lay : 2'd0;
      burst_len_m1_i = (c == 0) ? lm1 : 4'hF;
      hold_i         = hold_m[c];
      rst            = (c == rst_c);
      cfg_we_i       = (c == wr_c);
      cfg_layer_i    = wr_l; cfg_stride_i = wr_s; cfg_shift_i = wr_v;
      #1;
      q_src[c]  = src_valid_o;
      q_dst[c]  = dst_valid_o;
      q_last[c] = dst_last_o;
      q_done[c] = done_o;
      q_busy[c] = busy_o;
      if (c == 1) q_fac_c1 = w_fac;
      if (c == 2) q_fac_c2 = w_fac;
      tick();
    end
    start_i = 0; hold_i = 0; rst = 0; cfg_we_i = 0;
    q_fac_end = w_fac;
  endtask

  task automatic chk_pat(input string tag, input logic [31:0] s, input logic [31:0] d,
                         input logic [31:0] l, input logic [31:0] dn, input logic [31:0] b);
    chk({tag, ".src"},  q_src,  s);
    chk({tag, ".dst"},  q_dst,  d);
    chk({tag, ".last"}, q_last, l);
    chk({tag, ".done"}, q_done, dn);
    chk({tag, ".busy"}, q_busy, b);
  endtask

  initial begin
    rst = 1; cfg_we_i = 0; cfg_layer_i = 0; cfg_stride_i = 0; cfg_shift_i = 0;
    start_i = 0; layer_i = 0; burst_len_m1_i = 0; hold_i = 0;
    tick(); tick();
    rst = 0;
    tick();

    chk("rst.busy",  32'(busy_o), 0);
    chk("rst.done",  32'(done_o), 0);
    chk("rst.src",   32'(src_valid_o), 0);
    chk("rst.dst",   32'(dst_valid_o), 0);
    chk("rst.last",  32'(dst_last_o), 0);
    chk("rst.err",   32'(cfg_err_o), 0);
    chk("rst.fac",   32'(w_fac), 0);

    cfg_write(2, 0, 3);
    cfg_write(2, 1, 0);
    cfg_write(2, 2, 50);
    cfg_write(2, 3, 17);
    cfg_write(2, 4, 25);
    chk("wr.err_ok", 32'(cfg_err_o), 0);

    // len 4, no hold
    run_burst(2, 3, 0, 0, -1, 0, 0, 0, -1);
    chk_pat("b4", 32'h3C, 32'hF0, 32'h80, 32'h100, 32'h1FE);
    chk("b4.fac_load", 32'(q_fac_c1), 0);
    chk("b4.fac", 32'(q_fac_c2), 32'({6'd3, 6'd0, 6'd50, 6'd17, 6'd25}));
    chk("b4.fac_idle", 32'(q_fac_end), 32'({6'd3, 6'd0, 6'd50, 6'd17, 6'd25}));

    // rejected and boundary writes
    cfg_write(2, 0, 51);
    chk("err.shift51", 32'(cfg_err_o), 1);
    tick();
    chk("err.pulse_end", 32'(cfg_err_o), 0);
    cfg_write(2, 5, 7);
    chk("err.stride5", 32'(cfg_err_o), 1);
    cfg_write(1, 4, 50);
    chk("err.shift50_ok", 32'(cfg_err_o), 0);

    // restart request and write to the active layer during ISSUE
    run_burst(2, 3, 0, 32'h8, 3, 2, 1, 9, -1);
    chk_pat("restart", 32'h3C, 32'hF0, 32'h80, 32'h100, 32'h1FE);
    chk("restart.fac_idle", 32'(q_fac_end), 32'({6'd3, 6'd0, 6'd50, 6'd17, 6'd25}));

    // minimum burst; picks up the write made during the previous burst
    run_burst(2, 0, 0, 0, -1, 0, 0, 0, -1);
    chk_pat("min", 32'h4, 32'h10, 32'h10, 32'h20, 32'h3E);
    chk("min.fac", 32'(q_fac_c2), 32'({6'd3, 6'd9, 6'd50, 6'd17, 6'd25}));

    run_burst(1, 0, 0, 0, -1, 0, 0, 0, -1);
    chk("l1.fac", 32'(q_fac_c2), 32'({6'd0, 6'd0, 6'd0, 6'd0, 6'd50}));

    // len 2, hold on first ISSUE cycle
    run_burst(2, 1, 32'h4, 0, -1, 0, 0, 0, -1);
    chk_pat("hold", 32'h18, 32'h60, 32'h40, 32'h80, 32'hFE);

    // reset during DRAIN
    run_burst(2, 0, 0, 0, -1, 0, 0, 0, 3);
    chk_pat("rstdrain", 32'h4, 32'h0, 32'h0, 32'h0, 32'hE);
    chk("rstdrain.fac", 32'(q_fac_end), 0);

    // write on the LOAD edge: LOAD sees the old entry
    run_burst(3, 0, 0, 0, 1, 3, 0, 7, -1);
    chk("ldwr.fac_old", 32'(q_fac_c2), 0);
    run_burst(3, 0, 0, 0, -1, 0, 0, 0, -1);
    chk("ldwr.fac_new", 32'(q_fac_c2), 32'({6'd7, 6'd0, 6'd0, 6'd0, 6'd0}));

    // three bursts with four ISSUE hold cycles in total
    rst = 1; tick(); rst = 0;
    run_burst(0, 0, 32'hC, 0, -1, 0, 0, 0, -1);
    chk_pat("pA", 32'h10, 32'h40, 32'h40, 32'h80, 32'hFE);
    run_burst(0, 1, 32'h8, 0, -1, 0, 0, 0, -1);
    chk_pat("pB", 32'h14, 32'h50, 32'h40, 32'h80, 32'hFE);
    run_burst(0, 0, 32'h6, 0, -1, 0, 0, 0, -1);
    chk_pat("pC", 32'h8, 32'h20, 32'h20, 32'h40, 32'h7E);
`ifdef L1ROUTE_PERF_CNT_EN
    chk("perf.burst", 32'(perf_burst_cnt_o), 3);
    chk("perf.hold",  32'(perf_hold_cnt_o), 4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l1route_shift_scheduler.md
Name: l1route_shift_scheduler

Overview:
Sequencer for the column-wise 1st-level circular-shift router. That router has STRIDE_WIDTH stride units, each a 51-wide, 2-stage-pipelined QSN shifter, with no internal enable.
- Holds a per-layer, per-stride shift-factor table written over a config port.
- On a start request: latches one layer's factors, drives them to the five stride shift-factor inputs, and issues a burst of message beats.
- Tracks the shifter pipeline latency, flags valid outputs, and signals completion to the layer controller.

Parameters:
STRIDE_WIDTH, 5, number of stride units (shift-factor outputs)
STRIDE_UNIT_SIZE, 51, shifter length; legal shift range 0..STRIDE_UNIT_SIZE-1
BITWIDTH_SHIFT_FACTOR, 6, $clog2(STRIDE_UNIT_SIZE-1); shift-factor width
LAYER_NUM, 4, number of base-matrix layers held in the table
LAYER_W, 2, $clog2(LAYER_NUM)
SHIFTER_LATENCY, 2, pipeline depth of the shifter (input beat to output beat)
BURST_W, 4, width of burst-length field; burst = 1..2^BURST_W beats

Ports:
sys_clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
cfg_we_i  in  1  table write strobe
cfg_layer_i  in  LAYER_W  layer index of write
cfg_stride_i  in  3  stride index of write (0..STRIDE_WIDTH-1)
cfg_shift_i  in  BITWIDTH_SHIFT_FACTOR  shift value
cfg_err_o  out  1  1-cycle pulse: write rejected
start_i  in  1  request to run one burst
layer_i  in  LAYER_W  layer selected for the burst
burst_len_m1_i  in  BURST_W  burst length minus one
hold_i  in  1  upstream not ready; suppress beat issue this cycle
busy_o  out  1  high in every non-IDLE state
done_o  out  1  1-cycle completion pulse
stride0_shift_factor_o..stride4_shift_factor_o  out  BITWIDTH_SHIFT_FACTOR each  to shifter shift_factor inputs
src_valid_o  out  1  beat presented to shifter inputs this cycle
dst_valid_o  out  1  shifter output beat valid (src_valid_o delayed SHIFTER_LATENCY)
dst_last_o  out  1  qualifies final dst_valid_o beat of burst

Behaviour:
- Reset (rst=1 at an edge):
  - FSM goes to IDLE; table entries all 0.
  - All outputs 0 the following cycle, including shift factors.
  - Valid/last delay lines cleared.
  - Reset mid-burst aborts with no done_o.
- Config writes:
  - Accepted in any state when cfg_stride_i < STRIDE_WIDTH and cfg_shift_i < STRIDE_UNIT_SIZE.
  - Otherwise the table is unchanged and cfg_err_o pulses the next cycle.
  - A write becomes visible the cycle after the edge on which it is accepted.
  - A write to an entry on the same edge as LOAD reads it: LOAD gets the old value.
- FSM IDLE -> LOAD -> ISSUE -> DRAIN -> DONE -> IDLE:
  - IDLE: start_i sampled; if 1, latch layer_i and burst_len_m1_i, go to LOAD.
  - LOAD (1 cycle): register table[layer][0..4] onto strideN_shift_factor_o; load beat counter = burst_len_m1_i; go to ISSUE.
  - ISSUE: src_valid_o = !hold_i. Each issued beat decrements the counter. When the beat is issued with counter==0, drive the last flag into the delay line and go to DRAIN.
  - DRAIN: wait until the last beat exits the delay line (SHIFTER_LATENCY cycles after the last issue), then go to DONE.
  - DONE (1 cycle): done_o=1, then IDLE.
- Shift-factor hold: strideN_shift_factor_o stay stable from LOAD through DONE and keep their value in IDLE. The shifter pipeline therefore sees constant factors for every in-flight beat.
- start_i outside IDLE is ignored; there is no queue.
- hold_i is honoured only in ISSUE. The delay line always advances, since the shifter has no stall.
- Latency from start_i edge:
  - first src_valid_o at edge+2
  - first dst_valid_o at edge+2+SHIFTER_LATENCY
  - done_o one cycle after the final dst_valid_o
- Minimum burst (len 1, no hold): busy_o high for 1+1+SHIFTER_LATENCY+1 = 5 cycles.

Optional Feature:
Macro L1ROUTE_PERF_CNT_EN.
- Defined: adds outputs perf_burst_cnt_o[15:0] and perf_hold_cnt_o[15:0].
  - perf_burst_cnt_o counts DONE cycles.
  - perf_hold_cnt_o counts ISSUE cycles with hold_i=1.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/define file holds:
  - FSM state encoding: IDLE=0, LOAD=1, ISSUE=2, DRAIN=3, DONE=4
  - STRIDE_UNIT_SIZE, SHIFTER_LATENCY, BITWIDTH_SHIFT_FACTOR defaults, shared with the shifter wrapper
- One sub-module: l1route_valid_delay, a SHIFTER_LATENCY-deep shift register carrying {last, valid} with synchronous reset. It is reused wherever shifter outputs are qualified.

Test Plan:
- Reset then write table[2] = {3,0,50,17,25}; start layer 2, len_m1=3, hold_i=0 -> shift outputs {3,0,50,17,25} from edge+1; src_valid_o cycles 2..5; dst_valid_o 4..7; dst_last_o at 7; done_o at 8.
- Write cfg_shift_i=51 (and separately cfg_stride_i=5) -> cfg_err_o pulses; a following read-back burst shows old values unchanged.
- len_m1=1 with hold_i=1 on the first ISSUE cycle -> src_valid_o pattern 0,1,1; dst_valid_o follows 2 cycles later; done_o 1 cycle after the last dst_valid_o.
- start_i pulsed during ISSUE -> ignored; exactly one done_o. Write to the active layer during ISSUE -> outputs unchanged until the next LOAD.
- rst asserted during DRAIN -> next cycle busy_o, dst_valid_o, done_o, and shift outputs all 0; no done_o afterwards.
- With L1ROUTE_PERF_CNT_EN: 3 bursts, 4 hold cycles total -> perf_burst_cnt_o=3, perf_hold_cnt_o=4.
